// File: rtl/regfile_wr_arbiter_if.sv
// Signal bundle between the pipeline/mult-div side (master) and the RegFile write arbiter (slave).
// Forwarding outputs exist only when REGARB_FWD_EN is defined.
interface regfile_wr_arbiter_if #(parameter int DEPTH = 2);
  logic                      wb_wr;
  logic [4:0]                wb_addr;
  logic [31:0]               wb_data;
  logic                      md_valid;
  logic                      md_ready;
  logic [4:0]                md_addr;
  logic [31:0]               md_data;
  logic                      wb_stall;
  logic                      rf_wr;
  logic [4:0]                rf_addr;
  logic [31:0]               rf_data;
  logic [4:0]                rd_addr1;
  logic [4:0]                rd_addr2;
  logic                      hazard1;
  logic                      hazard2;
  logic [$clog2(DEPTH):0]    fifo_cnt;
`ifdef REGARB_FWD_EN
  logic [31:0]               fwd_data1;
  logic [31:0]               fwd_data2;
  logic                      fwd_hit1;
  logic                      fwd_hit2;

  modport master (output wb_wr, wb_addr, wb_data, md_valid, md_addr, md_data, rd_addr1, rd_addr2,
                  input  md_ready, wb_stall, rf_wr, rf_addr, rf_data, hazard1, hazard2, fifo_cnt,
                         fwd_data1, fwd_data2, fwd_hit1, fwd_hit2);
  modport slave  (input  wb_wr, wb_addr, wb_data, md_valid, md_addr, md_data, rd_addr1, rd_addr2,
                  output md_ready, wb_stall, rf_wr, rf_addr, rf_data, hazard1, hazard2, fifo_cnt,
                         fwd_data1, fwd_data2, fwd_hit1, fwd_hit2);
`else
  modport master (output wb_wr, wb_addr, wb_data, md_valid, md_addr, md_data, rd_addr1, rd_addr2,
                  input  md_ready, wb_stall, rf_wr, rf_addr, rf_data, hazard1, hazard2, fifo_cnt);
  modport slave  (input  wb_wr, wb_addr, wb_data, md_valid, md_addr, md_data, rd_addr1, rd_addr2,
                  output md_ready, wb_stall, rf_wr, rf_addr, rf_data, hazard1, hazard2, fifo_cnt);
`endif
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Arbitrates the single RegFile write port: WB first, queued mult/div results in idle slots,
// with a starvation-forced WB stall. Define REGARB_FWD_EN to add read-port forwarding.
module regfile_wr_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input logic                  clk,
  input logic                  reset,
  regfile_wr_arbiter_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int NUM_RD = 2;

  typedef enum logic {NORMAL, FORCE} state_e;

  logic [DEPTH-1:0]        vld;
  logic [DEPTH-1:0][4:0]   e_addr;
  logic [DEPTH-1:0][31:0]  e_data;
  logic [AW-1:0]           head, tail;
  logic [CW-1:0]           cnt;
  logic                    full, nonempty, head_vld;
  logic                    wb_gnt, md_gnt, deq, enq;
  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        sc_q, sc_d;
  logic                    stall_q, stall_d;
  logic                    rf_wr_q;
  logic [4:0]              rf_addr_q;
  logic [31:0]             rf_data_q;

  assign full     = cnt == CW'(DEPTH);
  assign nonempty = cnt != '0;
  assign head_vld = nonempty && vld[head];
  assign wb_gnt   = bus.wb_wr && (bus.wb_addr != 5'd0);
  assign md_gnt   = head_vld && !wb_gnt;
  // A killed head never needs the port, so it retires even while WB owns the slot.
  assign deq      = nonempty && (!vld[head] || !wb_gnt);
  assign enq      = bus.md_valid && !full && (bus.md_addr != 5'd0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      vld  <= '0;
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (wb_gnt && e_addr[i] == bus.wb_addr) vld[i] <= 1'b0;
      if (deq) begin
        vld[head] <= 1'b0;
        head      <= head + 1'b1;
      end
      if (enq) begin
        vld[tail]    <= 1'b1;
        e_addr[tail] <= bus.md_addr;
        e_data[tail] <= bus.md_data;
        tail         <= tail + 1'b1;
      end
      cnt <= cnt + CW'(enq) - CW'(deq);
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= NORMAL;
      sc_q    <= '0;
      stall_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sc_q    <= sc_d;
      stall_q <= stall_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    sc_d    = sc_q;
    case (state_q)
      NORMAL: begin
        if (head_vld && wb_gnt) begin
          if (sc_q == CNT_W'(STARVE_LIMIT - 1)) begin
            state_d = FORCE;
            sc_d    = '0;
          end else begin
            sc_d = sc_q + 1'b1;
          end
        end else if (md_gnt || !nonempty) begin
          sc_d = '0;
        end
      end
      FORCE: begin
        // A WB write here breaks the stall contract; it still wins and the force is retried.
        if (!wb_gnt) begin
          state_d = NORMAL;
          sc_d    = '0;
        end
      end
      default: state_d = NORMAL;
    endcase
  end

  // FSM: outputs
  always_comb begin
    stall_d = (state_d == FORCE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rf_wr_q   <= 1'b0;
      rf_addr_q <= '0;
      rf_data_q <= '0;
    end else if (wb_gnt) begin
      rf_wr_q   <= 1'b1;
      rf_addr_q <= bus.wb_addr;
      rf_data_q <= bus.wb_data;
    end else if (md_gnt) begin
      rf_wr_q   <= 1'b1;
      rf_addr_q <= e_addr[head];
      rf_data_q <= e_data[head];
    end else begin
      rf_wr_q   <= 1'b0;
      rf_addr_q <= '0;
      rf_data_q <= '0;
    end
  end

  logic [NUM_RD-1:0][4:0]  rd;
  logic [NUM_RD-1:0]       haz;
`ifdef REGARB_FWD_EN
  logic [NUM_RD-1:0][31:0] fwd_d;
  logic [NUM_RD-1:0]       hit;
`endif

  assign rd = {bus.rd_addr2, bus.rd_addr1};

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic        fm, rm, mm, nz;
    logic [31:0] fd;
    // Walk oldest to youngest so the youngest matching entry's data wins.
    always_comb begin
      fm = 1'b0;
      fd = '0;
      for (int k = 0; k < DEPTH; k++) begin
        if (vld[head + AW'(k)] && e_addr[head + AW'(k)] == rd[g]) begin
          fm = 1'b1;
          fd = e_data[head + AW'(k)];
        end
      end
    end
    assign nz = rd[g] != 5'd0;
    assign rm = rf_wr_q && (rf_addr_q == rd[g]);
    assign mm = enq && (bus.md_addr == rd[g]);
`ifdef REGARB_FWD_EN
    assign hit[g]   = nz && (fm || rm);
    assign fwd_d[g] = rm ? rf_data_q : fd;
    assign haz[g]   = nz && mm;
`else
    assign haz[g]   = nz && (fm || rm || mm);
`endif
  end

  assign bus.md_ready = !full;
  assign bus.wb_stall = stall_q;
  assign bus.rf_wr    = rf_wr_q;
  assign bus.rf_addr  = rf_addr_q;
  assign bus.rf_data  = rf_data_q;
  assign bus.hazard1  = haz[0];
  assign bus.hazard2  = haz[1];
  assign bus.fifo_cnt = cnt;
`ifdef REGARB_FWD_EN
  assign bus.fwd_data1 = fwd_d[0];
  assign bus.fwd_data2 = fwd_d[1];
  assign bus.fwd_hit1  = hit[0];
  assign bus.fwd_hit2  = hit[1];
`endif
endmodule
